// File: rtl/nibble_product_accumulator_pkg.sv
// Shared definitions for the nibble product accumulator: default width,
// FSM state encodings, step-counter width and the shift-select helper.
package nibble_product_accumulator_pkg;

  localparam int NIBBLE_W_DEF = 4;
  localparam int CNT_W        = 2;

  localparam logic [CNT_W-1:0] CNT_ZERO = 2'd0;
  localparam logic [CNT_W-1:0] CNT_ONE  = 2'd1;
  localparam logic [CNT_W-1:0] CNT_LAST = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } npa_state_e;

  // Number of nibble positions a partial product moves up: 0, 1 or 2.
  function automatic logic [1:0] shift_sel(input logic sel_a, input logic sel_b);
    return {1'b0, sel_a} + {1'b0, sel_b};
  endfunction

endpackage

// File: rtl/nibble_product_accumulator_if.sv
// Handshake bundle between the nibble operand muxes / 4x4 multiplier side
// (master) and the product accumulator (slave).
interface nibble_product_accumulator_if #(
  parameter int NIBBLE_W = 4
);

  logic                  start;
  logic [2*NIBBLE_W-1:0] pp_in;
  logic                  sel_a;
  logic                  sel_b;
  logic                  busy;
  logic                  done;
  logic [4*NIBBLE_W-1:0] product;

  modport master (
    output start,
    output pp_in,
    input  sel_a,
    input  sel_b,
    input  busy,
    input  done,
    input  product
  );

  modport slave (
    input  start,
    input  pp_in,
    output sel_a,
    output sel_b,
    output busy,
    output done,
    output product
  );

endinterface

// File: rtl/nibble_product_accumulator_shift_add.sv
// nibble_shift_add: combinational acc + (pp << NIBBLE_W*shift_sel),
// shift_sel in 0..2.
module nibble_shift_add #(
  parameter int NIBBLE_W = 4
) (
  input  logic [4*NIBBLE_W-1:0] acc,
  input  logic [2*NIBBLE_W-1:0] pp,
  input  logic [1:0]            shift_sel,
  output logic [4*NIBBLE_W-1:0] sum
);

  logic [4*NIBBLE_W-1:0] pp_ext_s;
  logic [4*NIBBLE_W-1:0] shifted_s;

  assign pp_ext_s = {{(2*NIBBLE_W){1'b0}}, pp};

  // Place the partial product at its nibble weight; shift_sel of 3 cannot occur.
  always_comb begin
    shifted_s = {(4*NIBBLE_W){1'b0}};
    case (shift_sel)
      2'd0:    shifted_s = pp_ext_s;
      2'd1:    shifted_s = pp_ext_s << NIBBLE_W;
      2'd2:    shifted_s = pp_ext_s << (2*NIBBLE_W);
      default: shifted_s = {(4*NIBBLE_W){1'b0}};
    endcase
  end

  assign sum = acc + shifted_s;

endmodule

// File: rtl/nibble_product_accumulator.sv
// Sequences the operand nibble selects, accumulates shifted 4x4 partial
// products into a 16-bit product. Optional NPA_PIPE_EN registers pp_in.
module nibble_product_accumulator
  import nibble_product_accumulator_pkg::*;
#(
  parameter int NIBBLE_W = NIBBLE_W_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  nibble_product_accumulator_if.slave  bus
);

  localparam int ACC_W = 4*NIBBLE_W;
  localparam logic [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};

  npa_state_e             state_r;
  npa_state_e             state_nxt_s;
  logic [CNT_W-1:0]       count_r;
  logic [CNT_W-1:0]       count_nxt_s;
  logic [ACC_W-1:0]       acc_r;
  logic [ACC_W-1:0]       acc_nxt_s;
  logic [ACC_W-1:0]       sum_s;
  logic                   sel_a_r;
  logic                   sel_b_r;
  logic                   sel_a_nxt_s;
  logic                   sel_b_nxt_s;
  logic                   busy_r;
  logic                   done_r;
  logic [2*NIBBLE_W-1:0]  add_pp_s;
  logic [1:0]             add_shift_s;

`ifdef NPA_PIPE_EN
  // Pipelined path: the adder sees last cycle's pp and select pair.
  logic                   drain_r;
  logic                   drain_nxt_s;
  logic [2*NIBBLE_W-1:0]  pp_q_r;
  logic [1:0]             shift_d_r;
  logic                   add_en_r;

  assign add_pp_s    = pp_q_r;
  assign add_shift_s = shift_d_r;
`else
  assign add_pp_s    = bus.pp_in;
  assign add_shift_s = shift_sel(sel_a_r, sel_b_r);
`endif

  nibble_shift_add #(
    .NIBBLE_W (NIBBLE_W)
  ) u_shift_add (
    .acc       (acc_r),
    .pp        (add_pp_s),
    .shift_sel (add_shift_s),
    .sum       (sum_s)
  );

  // Next-state, step counter and accumulator update.
  always_comb begin
    state_nxt_s = state_r;
    count_nxt_s = count_r;
    acc_nxt_s   = acc_r;
`ifdef NPA_PIPE_EN
    drain_nxt_s = drain_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_nxt_s = ST_ACC;
          count_nxt_s = CNT_ZERO;
          acc_nxt_s   = ACC_ZERO;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACC: begin
`ifdef NPA_PIPE_EN
        if (add_en_r) begin
          acc_nxt_s = sum_s;
        end else begin
          acc_nxt_s = acc_r;
        end
        // Fifth ACC cycle only drains the last registered partial product.
        if (drain_r) begin
          state_nxt_s = ST_DONE;
          count_nxt_s = CNT_ZERO;
          drain_nxt_s = 1'b0;
        end else begin
          state_nxt_s = ST_ACC;
          count_nxt_s = count_r + CNT_ONE;
          drain_nxt_s = (count_r == CNT_LAST);
        end
`else
        acc_nxt_s   = sum_s;
        count_nxt_s = count_r + CNT_ONE;
        if (count_r == CNT_LAST) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_ACC;
        end
`endif
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
        count_nxt_s = CNT_ZERO;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        count_nxt_s = CNT_ZERO;
        acc_nxt_s   = ACC_ZERO;
      end
    endcase
  end

  // Selects are registered from the next count so they line up with ACC cycles.
  always_comb begin
    sel_a_nxt_s = 1'b0;
    sel_b_nxt_s = 1'b0;
`ifdef NPA_PIPE_EN
    if ((state_nxt_s == ST_ACC) && !drain_nxt_s) begin
`else
    if (state_nxt_s == ST_ACC) begin
`endif
      sel_a_nxt_s = count_nxt_s[0];
      sel_b_nxt_s = count_nxt_s[1];
    end else begin
      sel_a_nxt_s = 1'b0;
      sel_b_nxt_s = 1'b0;
    end
  end

  // State, counter, accumulator and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      count_r <= CNT_ZERO;
      acc_r   <= ACC_ZERO;
      sel_a_r <= 1'b0;
      sel_b_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      count_r <= count_nxt_s;
      acc_r   <= acc_nxt_s;
      sel_a_r <= sel_a_nxt_s;
      sel_b_r <= sel_b_nxt_s;
      busy_r  <= (state_nxt_s == ST_ACC);
      done_r  <= (state_nxt_s == ST_DONE);
    end
  end

`ifdef NPA_PIPE_EN
  // Partial-product pipeline stage and its delayed step information.
  always_ff @(posedge clk) begin
    if (reset) begin
      drain_r   <= 1'b0;
      pp_q_r    <= {(2*NIBBLE_W){1'b0}};
      shift_d_r <= 2'd0;
      add_en_r  <= 1'b0;
    end else begin
      drain_r   <= drain_nxt_s;
      pp_q_r    <= bus.pp_in;
      shift_d_r <= shift_sel(sel_a_r, sel_b_r);
      add_en_r  <= (state_r == ST_ACC) && !drain_r;
    end
  end
`endif

  assign bus.sel_a   = sel_a_r;
  assign bus.sel_b   = sel_b_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.product = acc_r;

endmodule

// File: tb/tb_nibble_product_accumulator.sv
// Bench for nibble_product_accumulator: models the operand muxes and the
// 4x4 multiplier, checks vectors, corner sequences and random operands.
module tb_nibble_product_accumulator;

  localparam int NW = 4;
`ifdef NPA_PIPE_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 5;
`endif

  logic clk;
  logic reset;
  logic [7:0] op_a;
  logic [7:0] op_b;
  int checks;
  int errors;

  nibble_product_accumulator_if #(.NIBBLE_W(NW)) bus ();

  nibble_product_accumulator #(.NIBBLE_W(NW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Operand muxes feeding the 4x4 multiplier.
  always_comb begin
    logic [3:0] na;
    logic [3:0] nb;
    na = bus.sel_a ? op_a[7:4] : op_a[3:0];
    nb = bus.sel_b ? op_b[7:4] : op_b[3:0];
    bus.pp_in = {4'h0, na} * {4'h0, nb};
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Called just after a negedge; returns just after the negedge of the idle
  // cycle following done.
  task automatic run_mul(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
    op_a = a;
    op_b = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int i = 1; i <= LAT; i++) begin
      int step;
      logic exp_sa;
      logic exp_sb;
      @(negedge clk);
      step = i - 1;
      exp_sa = 1'b0;
      exp_sb = 1'b0;
      if (i < LAT && step < 4) begin
        exp_sa = step[0];
        exp_sb = step[1];
      end
      chk("sel_a", {31'd0, bus.sel_a}, {31'd0, exp_sa});
      chk("sel_b", {31'd0, bus.sel_b}, {31'd0, exp_sb});
      chk("busy", {31'd0, bus.busy}, (i < LAT) ? 32'd1 : 32'd0);
      chk("done", {31'd0, bus.done}, (i == LAT) ? 32'd1 : 32'd0);
      if (i == LAT) chk("product", {16'd0, bus.product}, {16'd0, exp});
    end
    @(negedge clk);
    chk("done_pulse_end", {31'd0, bus.done}, 32'd0);
    chk("product_hold", {16'd0, bus.product}, {16'd0, exp});
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{a: 8'h12, b: 8'h34, exp: 16'h03A8};
    tbl[1] = '{a: 8'hFF, b: 8'hFF, exp: 16'hFE01};
    tbl[2] = '{a: 8'h00, b: 8'hA5, exp: 16'h0000};
    tbl[3] = '{a: 8'h0F, b: 8'hF0, exp: 16'h0E10};
    tbl[4] = '{a: 8'h80, b: 8'h02, exp: 16'h0100};
    tbl[5] = '{a: 8'h03, b: 8'h05, exp: 16'h000F};

    checks = 0;
    errors = 0;
    op_a = 8'h00;
    op_b = 8'h00;
    bus.start = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_product", {16'd0, bus.product}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_sels", {30'd0, bus.sel_a, bus.sel_b}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Vector table; consecutive entries run back-to-back.
    for (int k = 0; k < 6; k++) run_mul(tbl[k].a, tbl[k].b, tbl[k].exp);

    // start held high: one multiply per IDLE acceptance.
    op_a = 8'h12;
    op_b = 8'h34;
    bus.start = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 2*LAT + 1; i++) begin
      @(negedge clk);
      chk("hold_done", {31'd0, bus.done}, (i == LAT || i == 2*LAT + 1) ? 32'd1 : 32'd0);
      chk("hold_busy", {31'd0, bus.busy},
          ((i < LAT) || (i >= LAT + 2 && i < 2*LAT + 1)) ? 32'd1 : 32'd0);
      if (i == 2*LAT + 1) bus.start = 1'b0;
    end
    @(negedge clk);
    chk("hold_product", {16'd0, bus.product}, 32'h03A8);
    chk("hold_no_third", {31'd0, bus.busy}, 32'd0);

    // Reset at ACC step 2 aborts with nothing kept.
    op_a = 8'hFF;
    op_b = 8'hFF;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_step2_sel_b", {31'd0, bus.sel_b}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_product", {16'd0, bus.product}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_sels", {30'd0, bus.sel_a, bus.sel_b}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_idle_done", {31'd0, bus.done}, 32'd0);
    run_mul(8'h0F, 8'hF0, 16'h0E10);

    // Random operands against the arithmetic reference a*b.
    for (int r = 0; r < 30; r++) begin
      logic [7:0]  ra;
      logic [7:0]  rb;
      logic [15:0] rexp;
      int gap;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rexp = 16'(ra) * 16'(rb);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        chk("rand_idle_busy", {31'd0, bus.busy}, 32'd0);
      end
      run_mul(ra, rb, rexp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
